dac_writer: RTL

- Transmit-side counterpart of the ADC readout path on the same board.
- Accepts packed two-channel samples on an AXI-Stream slave, buffers them in a small FIFO, converts and saturates each lane, then drives a single interleaved DAC data bus with A/B select and write strobes.
- Sits between DSP/AXIS logic and the DAC pins.
- Holds the last sample pair on underrun and reports it.

---
 rtl/dac_writer_pkg.sv | 40 ++++
 rtl/dac_writer_if.sv | 16 +
 rtl/dac_writer_fifo_sync.sv | 64 ++++++
 rtl/dac_writer.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/dac_writer_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// dac_writer_pkg : shared types, constants and lane conversion for dac_writer
// Rev 1.0
// -----------------------------------------------------------------------------
package dac_writer_pkg;

   localparam int LANE_WIDTH = 16;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_A    = 2'd1,
      S_B    = 2'd2
   } state_t;

   // Offset-binary zero for a DAC of the given width (width <= LANE_WIDTH).
   function automatic logic [LANE_WIDTH-1:0] midscale(input int width);
      return LANE_WIDTH'(1) << (width - 1);
   endfunction

   // Saturate a signed lane to width bits, then convert to offset binary.
   // Adding half-scale to an in-range value is the same as flipping its MSB.
   function automatic logic [LANE_WIDTH-1:0] lane_to_code(
      input logic signed [LANE_WIDTH-1:0] lane,
      input int                           width
   );
      int half;
      int v;
      half = 1 << (width - 1);
      v    = int'(lane);
      if (v > half - 1) begin
         v = half - 1;
      end else if (v < -half) begin
         v = -half;
      end
      return LANE_WIDTH'(v + half);
   endfunction

endpackage
`default_nettype wire

// File: rtl/dac_writer_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// dac_writer_if : AXI-Stream sample input (valid/ready/data)
// Rev 1.0
// -----------------------------------------------------------------------------
interface dac_writer_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  valid;
   logic                  ready;
   logic [DATA_WIDTH-1:0] data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);
endinterface
`default_nettype wire

// File: rtl/dac_writer_fifo_sync.sv
`default_nettype none
// -----------------------------------------------------------------------------
// fifo_sync : single-clock first-word-fall-through FIFO with level output
// Rev 1.0
// -----------------------------------------------------------------------------
module fifo_sync #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_wr_en,
   input  logic [DATA_WIDTH-1:0]   i_wr_data,
   input  logic                    i_rd_en,
   output logic [DATA_WIDTH-1:0]   o_rd_data,
   output logic                    o_full,
   output logic                    o_empty,
   output logic [$clog2(DEPTH):0]  o_level
);
   localparam int c_addr_w = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [c_addr_w-1:0]   r_wr_ptr;
   logic [c_addr_w-1:0]   r_rd_ptr;
   logic [c_addr_w:0]     r_level;
   logic                  w_wr;
   logic                  w_rd;

   assign o_full    = (r_level == (c_addr_w + 1)'(DEPTH));
   assign o_empty   = (r_level == '0);
   assign o_level   = r_level;
   assign o_rd_data = r_mem[r_rd_ptr];

   assign w_wr = i_wr_en & ~o_full;
   assign w_rd = i_rd_en & ~o_empty;

   // Storage is not reset; the pointers and level define what is valid.
   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[r_wr_ptr] <= i_wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_rd) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_wr, w_rd})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: rtl/dac_writer.sv
`default_nettype none
// -----------------------------------------------------------------------------
// dac_writer : buffers two-lane AXIS samples and drives an interleaved A/B DAC
// Rev 1.0
// -----------------------------------------------------------------------------
module dac_writer
   import dac_writer_pkg::*;
#(
   parameter int OUT_DAC_DATA_WIDTH  = 14,
   parameter int AXIS_DAC_DATA_WIDTH = 32,
   parameter int FIFO_DEPTH          = 8,
   parameter int UNDERRUN_CNT_WIDTH  = 16
) (
   input  logic                              in_clk,
   input  logic                              in_rst,
   input  logic                              in_enable,
   dac_writer_if.slave                       s_axis,
   output logic [OUT_DAC_DATA_WIDTH-1:0]     out_dac_data,
   output logic                              out_dac_sel,
   output logic                              out_dac_wrt,
   output logic                              out_underrun,
   output logic [UNDERRUN_CNT_WIDTH-1:0]     out_underrun_count,
   output logic [$clog2(FIFO_DEPTH):0]       out_fifo_level
);
   localparam logic [OUT_DAC_DATA_WIDTH-1:0] c_midscale =
      OUT_DAC_DATA_WIDTH'(midscale(OUT_DAC_DATA_WIDTH));

   state_t                            r_state;
   state_t                            w_next_state;
   logic [AXIS_DAC_DATA_WIDTH-1:0]    r_pair;
   logic [OUT_DAC_DATA_WIDTH-1:0]     r_dac_data;
   logic                              r_dac_sel;
   logic                              r_dac_wrt;
   logic                              r_underrun;
   logic [UNDERRUN_CNT_WIDTH-1:0]     r_underrun_count;

   logic                              w_accept;
   logic                              w_full;
   logic                              w_empty;
   logic [AXIS_DAC_DATA_WIDTH-1:0]    w_head;
   logic                              w_pop;
   logic                              w_underrun;
   logic [OUT_DAC_DATA_WIDTH-1:0]     w_code_a;
   logic [OUT_DAC_DATA_WIDTH-1:0]     w_code_b;
   logic [OUT_DAC_DATA_WIDTH-1:0]     w_dac_data;
   logic                              w_dac_sel;
   logic                              w_dac_wrt;

   // Ready is held low while reset is asserted, not just when full.
   assign s_axis.ready = ~w_full & ~in_rst;
   assign w_accept     = s_axis.valid & s_axis.ready;

   fifo_sync #(
      .DATA_WIDTH (AXIS_DAC_DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH)
   ) u_fifo (
      .clk       (in_clk),
      .rst       (in_rst),
      .i_wr_en   (w_accept),
      .i_wr_data (s_axis.data),
      .i_rd_en   (w_pop),
      .o_rd_data (w_head),
      .o_full    (w_full),
      .o_empty   (w_empty),
      .o_level   (out_fifo_level)
   );

   assign w_code_a = OUT_DAC_DATA_WIDTH'(
      lane_to_code(r_pair[LANE_WIDTH-1:0], OUT_DAC_DATA_WIDTH));
   assign w_code_b = OUT_DAC_DATA_WIDTH'(
      lane_to_code(r_pair[2*LANE_WIDTH-1:LANE_WIDTH], OUT_DAC_DATA_WIDTH));

   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_pop        = 1'b0;
      w_underrun   = 1'b0;
      w_dac_data   = c_midscale;
      w_dac_sel    = 1'b0;
      w_dac_wrt    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (in_enable && !w_empty) begin
               w_next_state = S_A;
               w_pop        = 1'b1;
            end
         end
         S_A: begin
            w_next_state = S_B;
            w_dac_data   = w_code_a;
            w_dac_wrt    = 1'b1;
         end
         S_B: begin
            w_dac_data = w_code_b;
            w_dac_sel  = 1'b1;
            w_dac_wrt  = 1'b1;
            // No bypass: a beat landing on this edge is too late to count.
            if (in_enable) begin
               w_next_state = S_A;
               if (!w_empty) begin
                  w_pop = 1'b1;
               end else begin
                  w_underrun = 1'b1;
               end
            end else begin
               w_next_state = S_IDLE;
            end
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         r_pair           <= '0;
         r_dac_data       <= c_midscale;
         r_dac_sel        <= 1'b0;
         r_dac_wrt        <= 1'b0;
         r_underrun       <= 1'b0;
         r_underrun_count <= '0;
      end else begin
         if (w_pop) begin
            r_pair <= w_head;
         end
         r_dac_data <= w_dac_data;
         r_dac_sel  <= w_dac_sel;
         r_dac_wrt  <= w_dac_wrt;
         if (w_underrun) begin
            r_underrun <= 1'b1;
            if (r_underrun_count != '1) begin
               r_underrun_count <= r_underrun_count + 1'b1;
            end
         end
      end
   end

   assign out_dac_data       = r_dac_data;
   assign out_dac_sel        = r_dac_sel;
   assign out_dac_wrt        = r_dac_wrt;
   assign out_underrun       = r_underrun;
   assign out_underrun_count = r_underrun_count;
endmodule
`default_nettype wire
